// File: rtl/keypad_pkg.sv
// Shared types and key-code helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_ONE   = 2'd1,
        FR_MULTI = 2'd2
    } frame_res_e;

    // Key code is 4*row + column.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

    // Number of asserted bits, saturating at 2 ("two or more").
    function automatic logic [1:0] low_count(input logic [3:0] low);
        logic [2:0] n;
        n = {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
        return (n >= 3'd2) ? 2'd2 : n[1:0];
    endfunction

    // Index of the asserted bit; only meaningful when exactly one bit is set.
    function automatic logic [1:0] low_index(input logic [3:0] low);
        logic [1:0] idx;
        case (low)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_prescaler.sv
// Scan tick generator: one-clk tick every SCAN_DIV clocks.
module keypad_prescaler
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count and tick
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
    end

    // Prescaler registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with frame-based debounce and one event pulse per press.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter int DEB_FRAMES    = 5,
    parameter int REPEAT_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       keyboard_en,
    output logic [3:0] keyboard_num,
    output logic       key_held
);

    if (SCAN_DIV < 2 || DEB_FRAMES < 1 || DEB_FRAMES > 15 || REPEAT_FRAMES < 1) begin : g_param_check
        $error("keypad_scan: illegal parameter value");
    end

    localparam logic [3:0] DEB_N = 4'(DEB_FRAMES);

    logic [3:0] row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [1:0] col_idx_q, col_idx_d;
    logic [3:0] col_q, col_d;
    logic [1:0] acc_cnt_q, acc_cnt_d;
    logic [3:0] acc_code_q, acc_code_d;
    state_e     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic       en_q, en_d;
    logic [3:0] num_q, num_d;
    logic       held_q, held_d;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_N = REP_W'(REPEAT_FRAMES);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    logic       tick_s;
    logic [3:0] low_s;
    logic [1:0] tick_keys_s;
    logic [2:0] sum_s;
    logic [1:0] frame_cnt_s;
    logic [3:0] frame_code_s;
    logic       frame_end_s;
    frame_res_e res_s;

    keypad_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    // Synchronizer, column rotation and per-frame key accumulation
    always_comb begin
        row_s1_d     = row;
        row_s2_d     = row_s1_q;
        low_s        = ~row_s2_q;
        tick_keys_s  = low_count(low_s);
        sum_s        = {1'b0, acc_cnt_q} + {1'b0, tick_keys_s};
        frame_cnt_s  = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        // The first key seen in the frame fixes the code; later keys only make it MULTI.
        frame_code_s = (acc_cnt_q == 2'd0) ? key_code(low_index(low_s), col_idx_q) : acc_code_q;
        frame_end_s  = tick_s && (col_idx_q == 2'd3);
        case (frame_cnt_s)
            2'd0:    res_s = FR_NONE;
            2'd1:    res_s = FR_ONE;
            default: res_s = FR_MULTI;
        endcase
        if (tick_s) begin
            col_idx_d = col_idx_q + 2'd1;
            col_d     = {col_q[2:0], col_q[3]};
            if (frame_end_s) begin
                acc_cnt_d  = 2'd0;
                acc_code_d = 4'd0;
            end else begin
                acc_cnt_d  = frame_cnt_s;
                acc_code_d = frame_code_s;
            end
        end else begin
            col_idx_d  = col_idx_q;
            col_d      = col_q;
            acc_cnt_d  = acc_cnt_q;
            acc_code_d = acc_code_q;
        end
    end

    // Debounce FSM, evaluated once per frame end
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        num_d   = num_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_q;
`endif
        if (frame_end_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (res_s == FR_ONE) begin
                        if (DEB_N == 4'd1) begin
                            state_d = ST_HELD;
                            en_d    = 1'b1;
                            num_d   = frame_code_s;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cand_d  = frame_code_s;
                            cnt_d   = 4'd1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (res_s == FR_ONE && frame_code_s == cand_q) begin
                        if (cnt_q + 4'd1 == DEB_N) begin
                            state_d = ST_HELD;
                            en_d    = 1'b1;
                            num_d   = cand_q;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (res_s == FR_NONE) begin
                        state_d = (DEB_N == 4'd1) ? ST_IDLE : ST_RELEASE;
                        cnt_d   = 4'd1;
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (res_s == FR_ONE && frame_code_s == num_q) begin
                            if (rep_q + REP_W'(1) == REP_N) begin
                                en_d  = 1'b1;
                                rep_d = '0;
                            end else begin
                                rep_d = rep_q + REP_W'(1);
                            end
                        end else begin
                            rep_d = '0;
                        end
`else
                        state_d = ST_HELD;
`endif
                    end
                end
                ST_RELEASE: begin
                    if (res_s == FR_NONE) begin
                        if (cnt_q + 4'd1 == DEB_N) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = '0;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
        held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q   <= 4'b1111;
            row_s2_q   <= 4'b1111;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
            state_q    <= ST_IDLE;
            cand_q     <= 4'd0;
            cnt_q      <= 4'd0;
            en_q       <= 1'b0;
            num_q      <= 4'h0;
            held_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            row_s1_q   <= row_s1_d;
            row_s2_q   <= row_s2_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            num_q      <= num_d;
            held_q     <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign col          = col_q;
    assign keyboard_en  = en_q;
    assign keyboard_num = num_q;
    assign key_held     = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad matrix model drives rows, a frame-level reference model predicts events.
module tb_keypad_scan;

    localparam int SCAN_DIV   = 4;
    localparam int DEB        = 2;
    localparam int REP        = 3;
    localparam int FRAME_CLKS = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic       keyboard_en;
    logic [3:0] keyboard_num;
    logic       key_held;

    logic [15:0] pressed = 16'h0000;
    int total = 0;
    int bad   = 0;

    // Reference model state: a press is a run of identical single-key frames
    bit         m_held;
    int         m_run;
    int         m_cand;
    int         m_rel;
    int         m_rep;
    logic [3:0] m_num;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB), .REPEAT_FRAMES(REP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .row          (row),
        .col          (col),
        .keyboard_en  (keyboard_en),
        .keyboard_num (keyboard_num),
        .key_held     (key_held)
    );

    always #5 clk = ~clk;

    // Matrix: a pressed key shorts its row to its column
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4*r+c] && col[c] == 1'b0) row[r] = 1'b0;
            end
        end
    end

    task automatic model_reset();
        m_held = 1'b0;
        m_run  = 0;
        m_cand = 0;
        m_rel  = 0;
        m_rep  = 0;
        m_num  = 4'h0;
    endtask

    task automatic model_frame(input logic [15:0] mask, output bit pulse);
        int n;
        int k;
        n = 0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) begin
                n++;
                k = i;
            end
        end
        pulse = 1'b0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run == 0) begin
                    m_cand = k;
                    m_run  = 1;
                end else if (k == m_cand) begin
                    m_run++;
                end else begin
                    m_run = 0;
                end
                if (m_run == DEB) begin
                    pulse  = 1'b1;
                    m_held = 1'b1;
                    m_num  = 4'(k);
                    m_rep  = 0;
                    m_rel  = 0;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (n == 0) begin
            m_rel++;
            m_rep = 0;
            if (m_rel == DEB) begin
                m_held = 1'b0;
                m_rel  = 0;
            end
        end else if (m_rel > 0) begin
            m_rel = 0;
            m_rep = 0;
        end else begin
`ifdef KEYPAD_REPEAT_EN
            if (n == 1 && k == int'(m_num)) begin
                m_rep++;
                if (m_rep == REP) begin
                    pulse = 1'b1;
                    m_rep = 0;
                end
            end else begin
                m_rep = 0;
            end
`endif
        end
    endtask

    // Wait for the first post-reset edge so that frames line up on 16-clock boundaries
    task automatic align_after_reset();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [15:0] mask, output int npulse);
        bit         exp_p;
        logic [3:0] exp_col;
        logic       exp_en;
        pressed = mask;
        model_frame(mask, exp_p);
        npulse = 0;
        for (int j = 1; j <= FRAME_CLKS; j++) begin
            @(posedge clk);
            @(negedge clk);
            exp_col = ~(4'b0001 << ((j / SCAN_DIV) % 4));
            exp_en  = (j == FRAME_CLKS) ? exp_p : 1'b0;
            total++;
            if (col !== exp_col) begin
                bad++;
                $display("FAIL col step=%0d got=%b exp=%b", j, col, exp_col);
            end
            total++;
            if (keyboard_en !== exp_en) begin
                bad++;
                $display("FAIL keyboard_en step=%0d mask=%h got=%b exp=%b", j, mask, keyboard_en, exp_en);
            end
            if (keyboard_en === 1'b1) npulse++;
        end
        total++;
        if (keyboard_num !== m_num) begin
            bad++;
            $display("FAIL keyboard_num mask=%h got=%h exp=%h", mask, keyboard_num, m_num);
        end
        total++;
        if (key_held !== m_held) begin
            bad++;
            $display("FAIL key_held mask=%h got=%b exp=%b", mask, key_held, m_held);
        end
    endtask

    task automatic run_frames(input logic [15:0] mask, input int n, output int npulse);
        int p;
        npulse = 0;
        for (int i = 0; i < n; i++) begin
            run_frame(mask, p);
            npulse += p;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        pressed = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (col !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b exp=1110", col); end
        total++;
        if (keyboard_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", keyboard_en); end
        total++;
        if (keyboard_num !== 4'h0) begin bad++; $display("FAIL reset_num got=%h exp=0", keyboard_num); end
        total++;
        if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b exp=0", key_held); end
        rst_n = 1'b1;
        align_after_reset();
    endtask

    task automatic test_single_press();
        int p;
        run_frames(16'h0040, 3, p);
        total++;
        if (p !== 1) begin bad++; $display("FAIL single_press_pulses got=%0d exp=1", p); end
        total++;
        if (keyboard_num !== 4'h6) begin bad++; $display("FAIL single_press_num got=%h exp=6", keyboard_num); end
        run_frames(16'h0000, 2, p);
    endtask

    task automatic test_bounce();
        int p;
        int q;
        run_frame(16'h0040, p);
        run_frame(16'h0000, q);
        p += q;
        run_frame(16'h0040, q);
        p += q;
        total++;
        if (p !== 0) begin bad++; $display("FAIL bounce_early_pulses got=%0d exp=0", p); end
        run_frame(16'h0040, q);
        total++;
        if (q !== 1) begin bad++; $display("FAIL bounce_final_pulse got=%0d exp=1", q); end
        run_frames(16'h0000, 2, p);
    endtask

    task automatic test_multi();
        int p;
        run_frames(16'h0021, 5, p);
        total++;
        if (p !== 0) begin bad++; $display("FAIL multi_pulses got=%0d exp=0", p); end
        total++;
        if (keyboard_num !== 4'h6) begin bad++; $display("FAIL multi_num got=%h exp=6", keyboard_num); end
        run_frames(16'h0000, 2, p);
    endtask

    task automatic test_hold_repeat();
        int p;
        int exp_p;
`ifdef KEYPAD_REPEAT_EN
        exp_p = 3;
`else
        exp_p = 1;
`endif
        run_frames(16'h0040, 10, p);
        total++;
        if (p !== exp_p) begin bad++; $display("FAIL hold_pulses got=%0d exp=%0d", p, exp_p); end
        run_frames(16'h0000, 2, p);
    endtask

    task automatic test_release_bounce();
        int p;
        run_frames(16'h0040, 2, p);
        total++;
        if (p !== 1) begin bad++; $display("FAIL release_first_pulse got=%0d exp=1", p); end
        run_frames(16'h0000, 1, p);
        run_frames(16'h0040, 2, p);
        total++;
        if (p !== 0) begin bad++; $display("FAIL release_short_gap got=%0d exp=0", p); end
        run_frames(16'h0000, 2, p);
        total++;
        if (key_held !== 1'b0) begin bad++; $display("FAIL release_idle_held got=%b exp=0", key_held); end
        run_frames(16'h0040, 2, p);
        total++;
        if (p !== 1) begin bad++; $display("FAIL release_new_press got=%0d exp=1", p); end
        run_frames(16'h0000, 2, p);
    endtask

    task automatic test_reset_mid();
        int p;
        run_frame(16'h0008, p);
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (col !== 4'b1110 || keyboard_en !== 1'b0 || keyboard_num !== 4'h0 || key_held !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_outputs got col=%b en=%b num=%h held=%b exp 1110/0/0/0",
                         col, keyboard_en, keyboard_num, key_held);
            end
        end
        rst_n = 1'b1;
        align_after_reset();
        run_frame(16'h0008, p);
        total++;
        if (p !== 0) begin bad++; $display("FAIL reset_mid_first_frame got=%0d exp=0", p); end
        run_frame(16'h0008, p);
        total++;
        if (p !== 1) begin bad++; $display("FAIL reset_mid_second_frame got=%0d exp=1", p); end
        total++;
        if (keyboard_num !== 4'h3) begin bad++; $display("FAIL reset_mid_num got=%h exp=3", keyboard_num); end
        run_frames(16'h0000, 2, p);
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int          r;
        int          a;
        int          b;
        int          p;
        mask = 16'h0000;
        for (int f = 0; f < 60; f++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                mask = mask;
            end else if (r < 6) begin
                mask = 16'h0000;
            end else if (r < 9) begin
                a    = int'($urandom_range(0, 15));
                mask = 16'h0001 << a;
            end else begin
                a    = int'($urandom_range(0, 15));
                b    = (a + 1 + int'($urandom_range(0, 14))) % 16;
                mask = (16'h0001 << a) | (16'h0001 << b);
            end
            run_frame(mask, p);
        end
        run_frames(16'h0000, 2, p);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi();
        test_hold_repeat();
        test_release_bounce();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving clk cycles per scan tick (1 ms at 50 MHz); legal range >=2.
REQ-002 The block SHALL have parameter DEB_FRAMES, default 5, giving consecutive identical frames needed to accept a press or release; legal range 1..15.
REQ-003 The block SHALL have parameter REPEAT_FRAMES, default 125, giving the auto-repeat interval in frames; used only when the Configuration macro is defined.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 row  input  4  keypad rows, active-low, asynchronous to clk.
REQ-007 col  output  4  column drive, active-low one-cold.
REQ-008 keyboard_en  output  1  one-clk pulse per accepted key event.
REQ-009 keyboard_num  output  4  code of the last accepted key; held between events.
REQ-010 key_held  output  1  high while an accepted key is still pressed.

Function
REQ-011 row SHALL pass through a 2-flop synchronizer before any use.
REQ-012 A prescaler SHALL emit a one-clk tick every SCAN_DIV clocks.
REQ-013 On each tick the block SHALL sample synchronized row for the current low column, then rotate col 1110->1101->1011->0111->1110.
REQ-014 Four consecutive ticks SHALL form one frame; frame result SHALL be NONE (0 keys), ONE(code) (exactly 1 key), or MULTI (>=2 keys).
REQ-015 Key code SHALL be 4*r + c, r = row index of the low row bit, c = column index.
REQ-016 FSM states SHALL be IDLE, DEBOUNCE, HELD, RELEASE, evaluated once per frame end.
REQ-017 IDLE: ONE(k) -> DEBOUNCE with candidate=k, count=1; otherwise stay.
REQ-018 DEBOUNCE: ONE(candidate) -> count+1; NONE, MULTI or ONE(other) -> IDLE with no output.
REQ-019 When count reaches DEB_FRAMES, in the clk after that frame's last tick, keyboard_en SHALL pulse for exactly one clk, keyboard_num SHALL update to candidate in the same clk, and state SHALL become HELD; DEB_FRAMES=1 accepts on the first ONE frame.
REQ-020 HELD: NONE -> RELEASE with count=1; ONE or MULTI -> stay, no pulse.
REQ-021 RELEASE: NONE -> count+1, reaching DEB_FRAMES -> IDLE; ONE or MULTI -> HELD.
REQ-022 key_held SHALL be 1 in HELD and RELEASE, 0 otherwise.
REQ-023 Without repeat, a held key SHALL produce exactly one keyboard_en pulse per press.

Reset
REQ-024 While rst_n=0: col=4'b1110, keyboard_en=0, keyboard_num=4'h0, key_held=0, state=IDLE, prescaler, column index and counters=0, synchronizer flops=4'b1111.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL discard the candidate and produce no pulse; after release, a still-pressed key SHALL need a full DEB_FRAMES debounce.

Configuration
REQ-026 Macro KEYPAD_REPEAT_EN defined: in HELD, ONE(keyboard_num) frames SHALL be counted, and every REPEAT_FRAMES of them keyboard_en SHALL pulse again with unchanged keyboard_num; the counter SHALL clear on entry to HELD and on any frame other than ONE(keyboard_num).
REQ-027 Macro undefined: no repeat counter SHALL exist, and HELD SHALL never pulse.

Structure
REQ-028 Package keypad_pkg SHALL hold the FSM state enum, frame-result encoding, and the code function/constants of REQ-015.
REQ-029 Sub-module keypad_prescaler (tick generator, parameter SCAN_DIV) SHALL be instantiated once; all other logic SHALL be in keypad_scan.

Verification (SCAN_DIV=4, DEB_FRAMES=2, REPEAT_FRAMES=3)
REQ-030 Row 1 low while col=1011 for 3 frames -> one keyboard_en pulse at end of frame 2, keyboard_num=4'h6, key_held=1.
REQ-031 Key 6 bounces (ONE, NONE, ONE, ONE) -> no pulse after the first frame, pulse after the 4th frame.
REQ-032 Keys 0 and 5 held together for 5 frames -> no pulse, keyboard_num unchanged.
REQ-033 Key 6 held 10 frames -> exactly 1 pulse without macro; 1 + 2 pulses (at 3 and 6 HELD frames) with KEYPAD_REPEAT_EN.
REQ-034 rst_n low for 3 clk during frame 2 of a key-3 press -> all outputs at reset values; pulse only 2 full frames after rst_n high.
REQ-035 Release of key 6 for 1 frame, then key 6 again -> no new pulse (RELEASE->HELD); release for 2 frames, then key 6 for 2 frames -> new pulse.
